// File: rtl/wide_add_sequencer.sv
// Multi-cycle controller for an external WORD_W-bit combinational adder: slices wide operands
// into chunks, feeds them LSW first with chained carry, and returns the registered wide sum.
module wide_add_sequencer #(
    parameter int unsigned WORD_W    = 32,
    parameter int unsigned NUM_WORDS = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [WORD_W*NUM_WORDS-1:0] in_a,
    input  logic [WORD_W*NUM_WORDS-1:0] in_b,
    input  logic                        in_cin,
    output logic [WORD_W-1:0]           add_a,
    output logic [WORD_W-1:0]           add_b,
    output logic                        add_cin,
    input  logic [WORD_W-1:0]           add_s,
    input  logic                        add_cout,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [WORD_W*NUM_WORDS-1:0] out_sum,
    output logic                        out_cout
);

    localparam int unsigned WideW = WORD_W * NUM_WORDS;
    localparam int unsigned IdxW  = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_WORDS - 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic [WideW-1:0]  a_q, a_d;
    logic [WideW-1:0]  b_q, b_d;
    logic [WideW-1:0]  sum_q, sum_d;
    logic              carry_q, carry_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        a_d       = a_q;
        b_d       = b_q;
        sum_d     = sum_q;
        carry_d   = carry_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        add_a     = '0;
        add_b     = '0;
        add_cin   = 1'b0;

        unique case (state_q)
            StIdle: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    a_d     = in_a;
                    b_d     = in_b;
                    carry_d = in_cin;
                    idx_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                // carry_q holds the previous chunk's carry-out, chaining the ripple across cycles
                add_a   = a_q[idx_q*WORD_W +: WORD_W];
                add_b   = b_q[idx_q*WORD_W +: WORD_W];
                add_cin = carry_q;
                sum_d[idx_q*WORD_W +: WORD_W] = add_s;
                carry_d = add_cout;
                if (idx_q == LastIdx) begin
                    state_d = StDone;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            StDone: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign out_sum  = sum_q;
    assign out_cout = carry_q;

endmodule

// File: tb/tb_wide_add_sequencer.sv
// Randomised self-checking bench for wide_add_sequencer with a behavioural 32-bit adder attached.
module tb_wide_add_sequencer;

    localparam int W    = 32;
    localparam int N    = 2;
    localparam int WIDE = W * N;

    logic            clk;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [WIDE-1:0] in_a;
    logic [WIDE-1:0] in_b;
    logic            in_cin;
    logic [W-1:0]    add_a;
    logic [W-1:0]    add_b;
    logic            add_cin;
    logic [W-1:0]    add_s;
    logic            add_cout;
    logic            out_valid;
    logic            out_ready;
    logic [WIDE-1:0] out_sum;
    logic            out_cout;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    wide_add_sequencer #(
        .WORD_W   (W),
        .NUM_WORDS(N)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a     (in_a),
        .in_b     (in_b),
        .in_cin   (in_cin),
        .add_a    (add_a),
        .add_b    (add_b),
        .add_cin  (add_cin),
        .add_s    (add_s),
        .add_cout (add_cout),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_sum  (out_sum),
        .out_cout (out_cout)
    );

    // The external combinational full adder
    assign {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b} + {{W{1'b0}}, add_cin};

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [WIDE:0] ref_sum(input logic [WIDE-1:0] a, input logic [WIDE-1:0] b,
                                              input logic cin);
        return {1'b0, a} + {1'b0, b} + {{WIDE{1'b0}}, cin};
    endfunction

    // Carry entering chunk i = carry out of the low i*W bits of the whole addition
    function automatic logic ref_chunk_cin(input logic [WIDE-1:0] a, input logic [WIDE-1:0] b,
                                           input logic cin, input int i);
        logic [WIDE:0] mask;
        logic [WIDE:0] part;
        mask = ({{WIDE{1'b0}}, 1'b1} << (W * i)) - 1;
        part = ({1'b0, a} & mask) + ({1'b0, b} & mask) + {{WIDE{1'b0}}, cin};
        return part[W * i];
    endfunction

    task automatic run_op(input logic [WIDE-1:0] a, input logic [WIDE-1:0] b, input logic cin,
                          input int hold);
        logic [WIDE:0] exp;
        int            r;
        bit            done;
        exp = ref_sum(a, b, cin);
        check_eq("idle_in_ready", in_ready, 1);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_cin   = cin;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_a     = {$urandom(), $urandom()};
        in_b     = {$urandom(), $urandom()};
        in_cin   = 1'($urandom_range(0, 1));
        r    = 0;
        done = 0;
        while (!done && r < 10) begin
            if (out_valid) begin
                done = 1;
            end else begin
                if (r < N) begin
                    check_eq("run_add_a", add_a, a[r*W +: W]);
                    check_eq("run_add_b", add_b, b[r*W +: W]);
                    check_eq("run_add_cin", add_cin, ref_chunk_cin(a, b, cin, r));
                end
                r++;
                @(negedge clk);
            end
        end
        check_eq("latency", r, N);
        if (done) begin
            check_eq("out_sum", out_sum, exp[WIDE-1:0]);
            check_eq("out_cout", out_cout, exp[WIDE]);
            check_eq("done_in_ready", in_ready, 0);
            check_eq("done_add_a", add_a, 0);
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                check_eq("hold_valid", out_valid, 1);
                check_eq("hold_sum", out_sum, exp[WIDE-1:0]);
                check_eq("hold_cout", out_cout, exp[WIDE]);
                check_eq("hold_in_ready", in_ready, 0);
            end
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
            check_eq("release_in_ready", in_ready, 1);
            check_eq("release_valid", out_valid, 0);
        end
    endtask

    task automatic back_to_back();
        logic [WIDE-1:0] a6[3];
        logic [WIDE-1:0] b6[3];
        logic            c6[3];
        logic [WIDE:0]   e6[3];
        int              acc[3];
        int              k;
        int              res;
        bit              pending;
        for (int i = 0; i < 3; i++) begin
            a6[i] = {$urandom(), $urandom()};
            b6[i] = {$urandom(), $urandom()};
            c6[i] = 1'($urandom_range(0, 1));
            e6[i] = ref_sum(a6[i], b6[i], c6[i]);
        end
        k = 0;
        res = 0;
        pending = 0;
        in_valid  = 1'b1;
        in_a      = a6[0];
        in_b      = b6[0];
        in_cin    = c6[0];
        out_ready = 1'b1;
        for (int t = 0; t < 40 && res < 3; t++) begin
            if (out_valid) begin
                check_eq("b2b_sum", out_sum, e6[res][WIDE-1:0]);
                check_eq("b2b_cout", out_cout, e6[res][WIDE]);
                res++;
            end
            if (in_ready && in_valid && k < 3) begin
                acc[k] = cyc;
                k++;
                pending = 1;
            end
            @(posedge clk);
            @(negedge clk);
            if (pending) begin
                pending = 0;
                if (k < 3) begin
                    in_a   = a6[k];
                    in_b   = b6[k];
                    in_cin = c6[k];
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check_eq("b2b_results", res, 3);
        check_eq("b2b_accepts", k, 3);
        if (k == 3) begin
            check_eq("b2b_space01", acc[1] - acc[0], N + 2);
            check_eq("b2b_space12", acc[2] - acc[1], N + 2);
        end
        @(negedge clk);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_cin    = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("rst_in_ready", in_ready, 1);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_out_sum", out_sum, 0);
        check_eq("rst_out_cout", out_cout, 0);
        check_eq("rst_add_a", add_a, 0);
        check_eq("rst_add_cin", add_cin, 0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(64'h00000000_FFFFFFFF, 64'h1, 1'b0, 0);
        run_op(64'hFFFFFFFF_FFFFFFFF, 64'hFFFFFFFF_FFFFFFFF, 1'b1, 1);
        run_op(64'h55555555_55555555, 64'hAAAAAAAA_AAAAAAAA, 1'b1, 0);
        run_op({$urandom(), $urandom()}, {$urandom(), $urandom()}, 1'b0, 5);

        // Reset while the second chunk is being processed
        in_valid = 1'b1;
        in_a     = {$urandom(), $urandom()};
        in_b     = {$urandom(), $urandom()};
        in_cin   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("midrun_rst_valid", out_valid, 0);
        check_eq("midrun_rst_in_ready", in_ready, 1);
        check_eq("midrun_rst_sum", out_sum, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op(64'd3, 64'd4, 1'b0, 0);

        back_to_back();

        for (int i = 0; i < 20; i++) begin
            run_op({$urandom(), $urandom()}, {$urandom(), $urandom()},
                   1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
